sync_trigger_gen: RTL and testbench

SYNC_TRIGGER_GEN -- requirements
Module: sync_trigger_gen

---
 rtl/sync_trigger_pkg.sv | 19 +
 rtl/sync_trigger_ch.sv | 161 ++++++++++++++++
 rtl/sync_trigger_gen.sv | 48 ++++
 tb/tb_sync_trigger_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_trigger_pkg.sv
// Shared types and constants for the sync/trigger generator: channel FSM encoding
// and the saturating missed-trigger counter.
package sync_trigger_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDly  = 2'd1,
        StHigh = 2'd2
    } ch_state_e;

    localparam int unsigned MissedWidth = 8;
    localparam logic [MissedWidth-1:0] MissedSat = {MissedWidth{1'b1}};
    localparam logic [MissedWidth-1:0] MissedOne = MissedWidth'(1);

    function automatic logic [MissedWidth-1:0] missed_inc(input logic [MissedWidth-1:0] v);
        return (v == MissedSat) ? v : v + MissedOne;
    endfunction

endpackage

// File: rtl/sync_trigger_ch.sv
// One sync/trigger channel: synchroniser with edge strobe, prescaler, pulse-train FSM
// and saturating missed-trigger counter.
module sync_trigger_ch
    import sync_trigger_pkg::*;
#(
    parameter int unsigned CntWidth = 16,
    parameter int unsigned PreWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sync_i,
    input  logic                   en_i,
    input  logic                   sw_start_i,
    input  logic [CntWidth-1:0]    delay_i,
    input  logic [CntWidth-1:0]    width_i,
    input  logic [CntWidth-1:0]    repeat_i,
    input  logic [PreWidth-1:0]    prescale_i,
    input  logic                   clear_missed_i,
    output logic                   strobe_o,
    output logic                   pulse_o,
    output logic                   busy_o,
    output logic [MissedWidth-1:0] missed_cnt_o
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [PreWidth-1:0] PreOne = PreWidth'(1);

    logic sync1_q, sync2_q, hist_q, strobe_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= sync_i;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            strobe_q <= sync2_q & ~hist_q;
        end
    end

    logic [PreWidth-1:0] pre_cnt_q;
    logic                pre_hit;
    logic                pre_fire;
    logic                trigger;

    // >= rather than == so a prescale lowered mid-count fires instead of wrapping.
    assign pre_hit  = (pre_cnt_q >= prescale_i);
    assign pre_fire = strobe_q & pre_hit;
    assign trigger  = (pre_fire | sw_start_i) & en_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_cnt_q <= '0;
        end else if (!en_i) begin
            pre_cnt_q <= '0;
        end else if (strobe_q) begin
            pre_cnt_q <= pre_hit ? '0 : pre_cnt_q + PreOne;
        end
    end

    ch_state_e           state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] delay_q;
    logic [CntWidth-1:0] width_q;
    logic [CntWidth-1:0] rep_q;
    logic                pulse_q;
    logic                busy_q;
    logic [CntWidth-1:0] width_eff;

    assign width_eff = (width_i == '0) ? CntOne : width_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            delay_q <= '0;
            width_q <= '0;
            rep_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!en_i) begin
            state_q <= StIdle;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        // Config is captured here so later port changes cannot disturb the run.
                        delay_q <= delay_i;
                        width_q <= width_eff;
                        rep_q   <= repeat_i;
                        busy_q  <= 1'b1;
                        if (delay_i != '0) begin
                            state_q <= StDly;
                            cnt_q   <= delay_i - CntOne;
                        end else begin
                            state_q <= StHigh;
                            cnt_q   <= width_eff - CntOne;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                StDly: begin
                    if (cnt_q == '0) begin
                        state_q <= StHigh;
                        cnt_q   <= width_q - CntOne;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StHigh: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else if (rep_q == '0) begin
                        state_q <= StIdle;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        rep_q <= rep_q - CntOne;
                        if (delay_q != '0) begin
                            state_q <= StDly;
                            cnt_q   <= delay_q - CntOne;
                            pulse_q <= 1'b0;
                        end else begin
                            cnt_q <= width_q - CntOne;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [MissedWidth-1:0] missed_q;

    // Clear wins over a coincident rejected trigger.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            missed_q <= '0;
        end else if (clear_missed_i) begin
            missed_q <= '0;
        end else if (trigger && (state_q != StIdle)) begin
            missed_q <= missed_inc(missed_q);
        end
    end

    assign strobe_o     = strobe_q;
    assign pulse_o      = pulse_q;
    assign busy_o       = busy_q;
    assign missed_cnt_o = missed_q;

endmodule

// File: rtl/sync_trigger_gen.sv
// Multi-channel sync/trigger pulse generator; one independent sync_trigger_ch per channel,
// each taking its own slice of the packed configuration buses.
module sync_trigger_gen
    import sync_trigger_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_CH-1:0]             SYNC_IN,
    input  logic [NUM_CH-1:0]             EN,
    input  logic [NUM_CH-1:0]             SW_START,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   DELAY,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   WIDTH,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   REPEAT,
    input  logic [NUM_CH*PRE_WIDTH-1:0]   PRESCALE,
    input  logic [NUM_CH-1:0]             CLEAR_MISSED,
    output logic [NUM_CH-1:0]             STROBE_OUT,
    output logic [NUM_CH-1:0]             PULSE_OUT,
    output logic [NUM_CH-1:0]             BUSY,
    output logic [NUM_CH*MissedWidth-1:0] MISSED_CNT
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_trigger_ch #(
            .CntWidth (CNT_WIDTH),
            .PreWidth (PRE_WIDTH)
        ) u_ch (
            .clk_i          (CLK),
            .rst_ni         (RST_N),
            .sync_i         (SYNC_IN[i]),
            .en_i           (EN[i]),
            .sw_start_i     (SW_START[i]),
            .delay_i        (DELAY[i*CNT_WIDTH +: CNT_WIDTH]),
            .width_i        (WIDTH[i*CNT_WIDTH +: CNT_WIDTH]),
            .repeat_i       (REPEAT[i*CNT_WIDTH +: CNT_WIDTH]),
            .prescale_i     (PRESCALE[i*PRE_WIDTH +: PRE_WIDTH]),
            .clear_missed_i (CLEAR_MISSED[i]),
            .strobe_o       (STROBE_OUT[i]),
            .pulse_o        (PULSE_OUT[i]),
            .busy_o         (BUSY[i]),
            .missed_cnt_o   (MISSED_CNT[i*MissedWidth +: MissedWidth])
        );
    end

endmodule

// File: tb/tb_sync_trigger_gen.sv
// Scoreboard bench for sync_trigger_gen: stimulus queues expected strobe/pulse/busy cycles
// per channel, a negedge monitor pops and compares them as the outputs appear.
module tb_sync_trigger_gen;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PW  = 8;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [NCH-1:0]      SYNC_IN, EN, SW_START, CLEAR_MISSED;
    logic [NCH-1:0]      STROBE_OUT, PULSE_OUT, BUSY;
    logic [NCH*CW-1:0]   DELAY, WIDTH, REPEAT;
    logic [NCH*PW-1:0]   PRESCALE;
    logic [NCH*8-1:0]    MISSED_CNT;

    sync_trigger_gen #(
        .NUM_CH    (NCH),
        .CNT_WIDTH (CW),
        .PRE_WIDTH (PW)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .SYNC_IN      (SYNC_IN),
        .EN           (EN),
        .SW_START     (SW_START),
        .DELAY        (DELAY),
        .WIDTH        (WIDTH),
        .REPEAT       (REPEAT),
        .PRESCALE     (PRESCALE),
        .CLEAR_MISSED (CLEAR_MISSED),
        .STROBE_OUT   (STROBE_OUT),
        .PULSE_OUT    (PULSE_OUT),
        .BUSY         (BUSY),
        .MISSED_CNT   (MISSED_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_pulse  [NCH][$];
    int exp_strobe [NCH][$];
    int exp_brise  [NCH][$];
    int exp_bfall  [NCH][$];

    logic           mon_en = 1'b0;
    logic [NCH-1:0] busy_prev = '0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every cycle, match observed outputs against queued expectations.
    always @(negedge CLK) begin
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (PULSE_OUT[c]) begin
                    if (exp_pulse[c].size() == 0) check($sformatf("pulse%0d_unexpected", c), cyc, -1);
                    else check($sformatf("pulse%0d_cycle", c), cyc, exp_pulse[c].pop_front());
                end else if (exp_pulse[c].size() != 0 && exp_pulse[c][0] == cyc) begin
                    check($sformatf("pulse%0d_high", c), 0, 1);
                    void'(exp_pulse[c].pop_front());
                end
                if (STROBE_OUT[c]) begin
                    if (exp_strobe[c].size() == 0) check($sformatf("strobe%0d_unexpected", c), cyc, -1);
                    else check($sformatf("strobe%0d_cycle", c), cyc, exp_strobe[c].pop_front());
                end else if (exp_strobe[c].size() != 0 && exp_strobe[c][0] == cyc) begin
                    check($sformatf("strobe%0d_high", c), 0, 1);
                    void'(exp_strobe[c].pop_front());
                end
                if (BUSY[c] && !busy_prev[c]) begin
                    if (exp_brise[c].size() == 0) check($sformatf("busy%0d_rise_unexpected", c), cyc, -1);
                    else check($sformatf("busy%0d_rise", c), cyc, exp_brise[c].pop_front());
                end
                if (!BUSY[c] && busy_prev[c]) begin
                    if (exp_bfall[c].size() == 0) check($sformatf("busy%0d_fall_unexpected", c), cyc, -1);
                    else check($sformatf("busy%0d_fall", c), cyc, exp_bfall[c].pop_front());
                end
            end
            busy_prev = BUSY;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int c, input int d, input int w, input int r, input int p);
        DELAY[c*CW +: CW]    = CW'(d);
        WIDTH[c*CW +: CW]    = CW'(w);
        REPEAT[c*CW +: CW]   = CW'(r);
        PRESCALE[c*PW +: PW] = PW'(p);
    endtask

    // Expected timeline of a sequence triggered in cycle t; abort_at < 0 means no abort.
    task automatic expect_seq(input int c, input int t, input int d, input int w, input int r,
                              input int abort_at);
        int we;
        int cy;
        we = (w == 0) ? 1 : w;
        exp_brise[c].push_back(t + 1);
        for (int k = 0; k <= r; k++) begin
            for (int j = 0; j < we; j++) begin
                cy = t + 1 + d + k * (d + we) + j;
                if (abort_at < 0 || cy <= abort_at) exp_pulse[c].push_back(cy);
            end
        end
        exp_bfall[c].push_back((abort_at < 0) ? t + 1 + (r + 1) * (d + we) : abort_at + 1);
    endtask

    task automatic fire(input logic [NCH-1:0] mask);
        SW_START = mask;
        tick();
        SW_START = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobe"}, int'(STROBE_OUT), 0);
        check({tag, "_pulse"},  int'(PULSE_OUT), 0);
        check({tag, "_busy"},   int'(BUSY), 0);
        check({tag, "_missed"}, int'(MISSED_CNT), 0);
    endtask

    int t;
    int cs;
    int remaining;

    initial begin
        RST_N = 1'b0;
        SYNC_IN = '0; EN = '0; SW_START = '0; CLEAR_MISSED = '0;
        DELAY = '0; WIDTH = '0; REPEAT = '0; PRESCALE = '0;
        repeat (3) tick();
        check_all_zero("reset");
        RST_N = 1'b1;
        EN = '1;
        tick();
        busy_prev = BUSY;
        mon_en = 1'b1;

        // Basic delayed pulse: DELAY=3 WIDTH=2 -> high T+4..T+5, busy T+1..T+5.
        cfg(0, 3, 2, 0, 0);
        t = cyc;
        expect_seq(0, t, 3, 2, 0, -1);
        fire(4'b0001);
        repeat (10) tick();

        // DELAY=0, WIDTH=0 (as 1), REPEAT=2 -> three back-to-back high cycles.
        cfg(1, 0, 0, 2, 0);
        t = cyc;
        expect_seq(1, t, 0, 0, 2, -1);
        fire(4'b0010);
        repeat (8) tick();

        // Prescale 2 on ch2: five sync edges, five strobes, one sequence on the third.
        cfg(2, 1, 1, 0, 2);
        for (int e = 0; e < 5; e++) begin
            cs = cyc;
            SYNC_IN[2] = 1'b1;
            exp_strobe[2].push_back(cs + 3);
            if (e == 2) expect_seq(2, cs + 3, 1, 1, 0, -1);
            repeat (2) tick();
            SYNC_IN[2] = 1'b0;
            repeat (4) tick();
        end
        repeat (6) tick();

        // Missed triggers while busy; config changes mid-run must not matter.
        cfg(3, 10, 5, 0, 0);
        t = cyc;
        expect_seq(3, t, 10, 5, 0, -1);
        fire(4'b1000);
        cfg(3, 2, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            fire(4'b1000);
        end
        check("missed3", int'(MISSED_CNT[3*8 +: 8]), 3);
        repeat (14) tick();
        check("missed3_hold", int'(MISSED_CNT[3*8 +: 8]), 3);

        // Clear coinciding with a miss, then 300 misses saturate at 255, then EN abort.
        cfg(3, 1000, 1, 0, 0);
        t = cyc;
        expect_seq(3, t, 1000, 1, 0, t + 302);
        SW_START[3] = 1'b1;
        tick();
        CLEAR_MISSED[3] = 1'b1;
        tick();
        CLEAR_MISSED[3] = 1'b0;
        check("missed_clear", int'(MISSED_CNT[3*8 +: 8]), 0);
        repeat (300) tick();
        SW_START[3] = 1'b0;
        check("missed_sat", int'(MISSED_CNT[3*8 +: 8]), 255);
        EN[3] = 1'b0;
        tick();
        check("abort_dly_busy", int'(BUSY[3]), 0);
        EN[3] = 1'b1;
        repeat (3) tick();

        // EN dropped mid-HIGH on ch0.
        cfg(0, 2, 6, 0, 0);
        t = cyc;
        expect_seq(0, t, 2, 6, 0, t + 5);
        fire(4'b0001);
        repeat (4) tick();
        EN[0] = 1'b0;
        tick();
        check("abort_high_pulse", int'(PULSE_OUT[0]), 0);
        check("abort_high_busy", int'(BUSY[0]), 0);
        EN[0] = 1'b1;
        repeat (3) tick();

        // Four channels, distinct configs, same trigger cycle.
        cfg(0, 1, 2, 1, 0);
        cfg(1, 0, 3, 0, 0);
        cfg(2, 2, 0, 2, 0);
        cfg(3, 4, 1, 1, 0);
        t = cyc;
        expect_seq(0, t, 1, 2, 1, -1);
        expect_seq(1, t, 0, 3, 0, -1);
        expect_seq(2, t, 2, 0, 2, -1);
        expect_seq(3, t, 4, 1, 1, -1);
        fire(4'b1111);
        for (int c = 0; c < NCH; c++) cfg(c, 7, 7, 7, 0);
        repeat (16) tick();

        // Reset mid-DLY: everything, missed counters included, back to 0 next edge.
        cfg(0, 20, 2, 0, 0);
        t = cyc;
        expect_seq(0, t, 20, 2, 0, t + 5);
        fire(4'b0001);
        repeat (4) tick();
        RST_N = 1'b0;
        tick();
        check_all_zero("reset_mid");
        RST_N = 1'b1;
        repeat (4) tick();

        remaining = 0;
        for (int c = 0; c < NCH; c++) remaining += exp_pulse[c].size();
        check("pulse_queue_drained", remaining, 0);
        remaining = 0;
        for (int c = 0; c < NCH; c++) remaining += exp_strobe[c].size();
        check("strobe_queue_drained", remaining, 0);
        remaining = 0;
        for (int c = 0; c < NCH; c++) remaining += exp_brise[c].size() + exp_bfall[c].size();
        check("busy_queue_drained", remaining, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
